lsu_align_unit: RTL

- Parametrised load/store alignment unit between the execute/memory pipeline stage and a word-addressed data memory port.
- Decodes funct3 size/sign and generates byte enables. Shifts store data onto the correct byte lanes.
- Extracts and sign- or zero-extends load data.
- Splits misaligned accesses that cross a word boundary into two bus beats under a small FSM, with valid/ready handshakes on both sides.

---
 rtl/lsu_align_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_align_unit.sv
// Load/store alignment: funct3 decode, byte-lane steering, load extension, word-crossing split.
// Latency: aligned 3 cycles, split 5 cycles, error 1 cycle after accept (1-cycle memory response).
// Backpressure: i_req accepted only in IDLE; beat outputs hold stable until i_mem_req_ready.
module lsu_align_unit #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [2:0]          i_req_funct,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_we,
  output logic [XLEN/8-1:0]   o_mem_be,
  output logic [XLEN-1:0]     o_mem_wdata,
  input  logic                i_mem_rsp_valid,
  input  logic [XLEN-1:0]     i_mem_rdata,
  output logic                o_rsp_valid,
  output logic [XLEN-1:0]     o_rsp_rdata,
  output logic                o_rsp_err
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_RESP} state_t;

  // log2 of the access size in bytes
  function automatic logic [1:0] f_lg(input logic [2:0] funct);
    return funct[1:0];
  endfunction

  // signed loads are the 0xx encodings; 1xx are unsigned
  function automatic logic f_sgn(input logic [2:0] funct);
    return ~funct[2];
  endfunction

  // 011/110 exist only on 64-bit; unsigned encodings are load-only
  function automatic logic f_legal(input logic we, input logic [2:0] funct);
    logic ok;
    ok = 1'b0;
    case (funct)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (XLEN == 64);
      3'b100, 3'b101:         ok = ~we;
      3'b110:                 ok = ~we && (XLEN == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // access runs past the last lane of the word
  function automatic logic f_cross(input logic [OFFW-1:0] off, input logic [1:0] lg);
    logic [4:0] w_end;
    w_end = 5'(off) + (5'd1 << lg);
    return w_end > 5'(NB);
  endfunction

  state_t              r_state, w_next;
  logic                r_we, r_err, r_cross;
  logic [2:0]          r_funct;
  logic [ADDR_W-1:0]   r_addr;
  logic [XLEN-1:0]     r_wdata, r_lo, r_hi;

  logic                w_accept, w_in_cross, w_in_err;
  logic [1:0]          w_lg;
  logic [OFFW-1:0]     w_off;
  logic [ADDR_W-1:0]   w_base;
  logic [2*NB-1:0]     w_mask, w_be_full;
  logic [2*XLEN-1:0]   w_wd_full;
  logic [XLEN-1:0]     w_raw, w_keep, w_ext;
  logic                w_msb;

  assign w_accept   = i_req_valid && (r_state == S_IDLE);
  assign w_in_cross = f_cross(i_req_addr[OFFW-1:0], f_lg(i_req_funct));
  assign w_in_err   = ~f_legal(i_req_we, i_req_funct) || (w_in_cross && (MISALIGN_EN == 0));

  assign w_lg      = f_lg(r_funct);
  assign w_off     = r_addr[OFFW-1:0];
  assign w_base    = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign w_be_full = w_mask << w_off;
  assign w_wd_full = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_raw     = XLEN'({r_hi, r_lo} >> {w_off, 3'b000});
  assign w_ext     = (w_raw & w_keep) | ({XLEN{f_sgn(r_funct) & w_msb}} & ~w_keep);

  // size-dependent lane mask, kept-bit mask and sign bit of the merged field
  always_comb begin
    w_mask = '0;
    w_keep = '1;
    w_msb  = 1'b0;
    case (w_lg)
      2'd0: begin w_mask = (2*NB)'(4'h1); w_keep = XLEN'(8'hFF);         w_msb = w_raw[7];      end
      2'd1: begin w_mask = (2*NB)'(4'h3); w_keep = XLEN'(16'hFFFF);      w_msb = w_raw[15];     end
      2'd2: begin w_mask = (2*NB)'(4'hF); w_keep = XLEN'(32'hFFFF_FFFF); w_msb = w_raw[31];     end
      default: begin w_mask = (2*NB)'(8'hFF); w_keep = '1;               w_msb = w_raw[XLEN-1]; end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // request latch and read-beat capture buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_cross <= 1'b0;
      r_funct <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= i_req_we;
        r_err   <= w_in_err;
        r_cross <= w_in_cross;
        r_funct <= i_req_funct;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_hi    <= '0;
      end
      if (r_state == S_WAIT0 && i_mem_rsp_valid) r_lo <= i_mem_rdata;
      if (r_state == S_WAIT1 && i_mem_rsp_valid) r_hi <= i_mem_rdata;
    end
  end

  // next state and per-state outputs; everything idles at zero outside its state
  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_addr      = '0;
    o_mem_we        = 1'b0;
    o_mem_be        = '0;
    o_mem_wdata     = '0;
    o_rsp_valid     = 1'b0;
    o_rsp_rdata     = '0;
    o_rsp_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = w_in_err ? S_RESP : S_BEAT0;
      end
      S_BEAT0: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = w_base;
        o_mem_we        = r_we;
        o_mem_be        = w_be_full[NB-1:0];
        o_mem_wdata     = w_wd_full[XLEN-1:0];
        if (i_mem_req_ready) w_next = S_WAIT0;
      end
      S_WAIT0: begin
        if (i_mem_rsp_valid) w_next = r_cross ? S_BEAT1 : S_RESP;
      end
      S_BEAT1: begin
        o_mem_req_valid = 1'b1;
        o_mem_addr      = w_base + ADDR_W'(NB);
        o_mem_we        = r_we;
        o_mem_be        = w_be_full[2*NB-1:NB];
        o_mem_wdata     = w_wd_full[2*XLEN-1:XLEN];
        if (i_mem_req_ready) w_next = S_WAIT1;
      end
      S_WAIT1: begin
        if (i_mem_rsp_valid) w_next = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = r_err;
        o_rsp_rdata = (r_err || r_we) ? '0 : w_ext;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
